rv_regfile_scoreboard: RTL
==========================

// Module: rv_regfile_scoreboard
// PURPOSE
//  Parametrised integer register file for the RV32E/RV32I core: NR_RD combinational read ports, two write-back
//  ports and a per-register busy scoreboard. Sits between decode/issue (reads operands, claims rd) and
//  write-back (returns results, releases rd). x0 is hardwired to zero and is never busy.
// PARAMETERS
//  XLEN      32   data width of each register
//  NUM_REGS  16   architectural registers (16 = RV32E, 32 = RV32I); power of two
//  NR_RD     2    number of read ports (1..4)
//  AW        $clog2(NUM_REGS)   derived address width; not overridden
// PORTS
//  clk        in   1           clock, all state updates on posedge
//  rst        in   1           synchronous, active-high reset
//  rd_addr    in   NR_RD*AW    packed read addresses, port i at [i*AW +: AW]
//  rd_data    out  NR_RD*XLEN  packed read data
//  rd_busy    out  NR_RD       1 = register on port i has a pending write
//  iss_valid  in   1           issue stage claims destination iss_rd
//  iss_rd     in   AW          destination being claimed
//  iss_ready  out  1           claim accepted this cycle
//  wb0_en     in   1           write port 0 enable
//  wb0_addr   in   AW          write port 0 address
//  wb0_data   in   XLEN        write port 0 data
//  wb1_en     in   1           write port 1 enable (higher priority)
//  wb1_addr   in   AW          write port 1 address
//  wb1_data   in   XLEN        write port 1 data
// BEHAVIOUR
//  - Reset: all NUM_REGS entries <= 0, all busy bits <= 0; rd_data reads 0, rd_busy 0, iss_ready 1 next cycle.
//  - rst in the same cycle as any write/issue: reset wins; the write/claim is discarded.
//  - Reads: combinational, 0-cycle latency from rd_addr; rd_addr==0 -> rd_data 0, rd_busy 0.
//  - Writes: commit on posedge when wbN_en && wbN_addr!=0; writes to x0 are dropped (no state change).
//  - wb0 and wb1 to the same non-zero address in one cycle: wb1 data is stored; both clear busy.
//  - Scoreboard: busy[r] set on posedge when iss_valid && iss_ready && iss_rd!=0.
//    busy[r] cleared on posedge when any wbN_en with wbN_addr==r.
//    Same-cycle claim and write-back of the same r: write commits, busy stays 1 (new owner pending).
//  - iss_ready = !busy[iss_rd] (WAW stall); iss_rd==0 -> iss_ready 1, nothing recorded.
//    iss_ready is independent of iss_valid and does not depend on same-cycle write-back.
//  - Write-back to a non-busy register is legal: data commits, busy stays 0.
//  - Same-cycle read/write of one address without bypass: rd_data shows the old value, rd_busy shows the pre-clear value.
//  - No address range checks: every AW-bit address is a valid register because NUM_REGS = 2**AW.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: write-to-read forwarding. A read of r returns the same-cycle wbN_data
//    (wb1 over wb0) when wbN_en && wbN_addr==r && r!=0, and rd_busy for that port reads 0 that cycle.
//  Not defined: reads see stored state only; the new value is visible one cycle after the write edge.
// STRUCTURE
//  - Shared package/include (RV32E.vh): XLEN default, NUM_REGS default, REG_ZERO constant.
//  - One sub-module: rv_regfile_read_port (one instance per read port via generate): mux, x0 zeroing,
//    optional bypass. Storage, write logic and scoreboard stay in the top module.
// TESTING
//  1 rst 1 cycle -> all 16 regs read 0, rd_busy=0, iss_ready=1.
//  2 wb0 x5<=0xDEADBEEF; next cycle rd_addr0=5 -> 0xDEADBEEF; wb0 x0<=0x1234 -> x0 still reads 0.
//  3 issue x7 -> busy[7]=1, a second issue x7 sees iss_ready=0; wb1 x7<=0x55 -> busy clears, rd reads 0x55.
//  4 wb0 x3<=0xAAAA and wb1 x3<=0xBBBB same cycle -> x3=0xBBBB; issue x9 + wb x9 same cycle -> busy[9]=1.
//  5 BYPASS_EN: wb0 x4<=0x77 with rd_addr1=4 same cycle -> rd_data1=0x77. Without it -> old value, then 0x77 next cycle.
//  6 write x1..x15, assert rst mid-stream with a wb pending -> all 0, pending write lost; NUM_REGS=32 rerun passes 1-5.

Source files
------------

// File: rtl/rv_regfile_scoreboard_pkg.sv
// Shared constants for the integer register file: default widths and the hardwired-zero register index.
package rv_regfile_scoreboard_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int NUM_REGS_DEF = 16;   // RV32E; 32 for RV32I
    localparam int REG_ZERO     = 0;

endpackage

// File: rtl/rv_regfile_read_port.sv
// One combinational read port: register mux, x0 zeroing and, with REGFILE_BYPASS_EN defined,
// same-cycle write-back forwarding (wb1 over wb0) that also masks the busy bit.
module rv_regfile_read_port
    import rv_regfile_scoreboard_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic [AW-1:0]            addr_i,
    input  logic [NUM_REGS*XLEN-1:0] regs_i,
    input  logic [NUM_REGS-1:0]      busy_i,
    input  logic                     wb0_en_i,
    input  logic [AW-1:0]            wb0_addr_i,
    input  logic [XLEN-1:0]          wb0_data_i,
    input  logic                     wb1_en_i,
    input  logic [AW-1:0]            wb1_addr_i,
    input  logic [XLEN-1:0]          wb1_data_i,
    output logic [XLEN-1:0]          data_o,
    output logic                     busy_o
);

`ifndef REGFILE_BYPASS_EN
    logic unused_wb;
    assign unused_wb = ^{wb0_en_i, wb0_addr_i, wb0_data_i, wb1_en_i, wb1_addr_i, wb1_data_i};
`endif

    always_comb begin
        data_o = regs_i[addr_i*XLEN +: XLEN];
        busy_o = busy_i[addr_i];
`ifdef REGFILE_BYPASS_EN
        if (wb0_en_i && wb0_addr_i == addr_i) begin
            data_o = wb0_data_i;
            busy_o = 1'b0;
        end
        if (wb1_en_i && wb1_addr_i == addr_i) begin
            data_o = wb1_data_i;
            busy_o = 1'b0;
        end
`endif
        // x0 wins over any forwarded value
        if (addr_i == AW'(REG_ZERO)) begin
            data_o = '0;
            busy_o = 1'b0;
        end
    end

endmodule

// File: rtl/rv_regfile_scoreboard.sv
// Integer register file with NR_RD read ports, two write-back ports and a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data to the read ports.
module rv_regfile_scoreboard
    import rv_regfile_scoreboard_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NR_RD    = 2,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NR_RD*AW-1:0]   rd_addr,
    output logic [NR_RD*XLEN-1:0] rd_data,
    output logic [NR_RD-1:0]      rd_busy,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_rd,
    output logic                  iss_ready,
    input  logic                  wb0_en,
    input  logic [AW-1:0]         wb0_addr,
    input  logic [XLEN-1:0]       wb0_data,
    input  logic                  wb1_en,
    input  logic [AW-1:0]         wb1_addr,
    input  logic [XLEN-1:0]       wb1_data
);

    logic [XLEN-1:0]          regs_q [NUM_REGS];
    logic [XLEN-1:0]          regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]      busy_q, busy_d;
    logic [NUM_REGS*XLEN-1:0] regs_flat;

    logic wb0_act, wb1_act, claim;

    assign wb0_act = wb0_en && (wb0_addr != AW'(REG_ZERO));
    assign wb1_act = wb1_en && (wb1_addr != AW'(REG_ZERO));

    // WAW stall only looks at registered busy; busy_q[0] is never set, so x0 is always ready
    assign iss_ready = !busy_q[iss_rd];
    assign claim     = iss_valid && iss_ready && (iss_rd != AW'(REG_ZERO));

    always_comb begin
        regs_d = regs_q;
        if (wb0_act) regs_d[wb0_addr] = wb0_data;
        if (wb1_act) regs_d[wb1_addr] = wb1_data;
    end

    // Clear before set: a same-cycle claim leaves the new owner pending
    always_comb begin
        busy_d = busy_q;
        if (wb0_act) busy_d[wb0_addr] = 1'b0;
        if (wb1_act) busy_d[wb1_addr] = 1'b0;
        if (claim)   busy_d[iss_rd]   = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*XLEN +: XLEN] = regs_q[g];
    end

    for (genvar i = 0; i < NR_RD; i++) begin : g_rd
        rv_regfile_read_port #(
            .XLEN     (XLEN),
            .NUM_REGS (NUM_REGS),
            .AW       (AW)
        ) u_rd (
            .addr_i     (rd_addr[i*AW +: AW]),
            .regs_i     (regs_flat),
            .busy_i     (busy_q),
            .wb0_en_i   (wb0_en),
            .wb0_addr_i (wb0_addr),
            .wb0_data_i (wb0_data),
            .wb1_en_i   (wb1_en),
            .wb1_addr_i (wb1_addr),
            .wb1_data_i (wb1_data),
            .data_o     (rd_data[i*XLEN +: XLEN]),
            .busy_o     (rd_busy[i])
        );
    end

endmodule
